// File: rtl/rsa_modexp_param_if.sv
// Byte-wide host bus of the RSA modular exponentiation block: operand and
// result access, start/mode control and completion status.
interface rsa_modexp_param_if #(
    parameter int AW = 5
);
    logic          we;
    logic          oe;
    logic          start;
    logic          mode;
    logic [1:0]    reg_sel;
    logic [AW-1:0] addr;
    logic [7:0]    data_i;
    logic [7:0]    data_o;
    logic          ready;
    logic          done;
    logic          err;

    modport master (
        output we, oe, start, mode, reg_sel, addr, data_i,
        input  data_o, ready, done, err
    );

    modport slave (
        input  we, oe, start, mode, reg_sel, addr, data_i,
        output data_o, ready, done, err
    );
endinterface

// File: rtl/rsa_modexp_param.sv
// Left-to-right square-and-multiply modular exponentiation (mode 0) or a
// single modular multiply (mode 1), built on a bit-serial interleaved multiplier.
module rsa_modexp_param #(
    parameter int WIDTH = 256,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    rsa_modexp_param_if.slave    bus
);
    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, INIT, SQR, MUL, FIN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] m_reg, e_reg, n_reg, result, acc, p;
    logic [IW-1:0]    bit_idx, cnt;
    logic             mode_r, err_r;

    logic [AW-1:0]    addr;
    logic             addr_ok, start_go, operands_bad, cnt_last;
    logic [7:0]       rd_byte;

    assign addr         = bus.addr;
    assign addr_ok      = (32'(addr) < NB);
    assign bus.ready    = (state == IDLE);
    assign bus.done     = (state == FIN);
    assign bus.err      = err_r;
    assign start_go     = bus.ready && bus.start && !bus.we;
    assign operands_bad = (n_reg == '0) || (m_reg >= n_reg);
    assign cnt_last     = (cnt == '0);

    // ---------------------------------------------------------------
    // Bit-serial multiplier step: p <- (2p mod N + y_j*X) mod N.
    // Both partial sums stay below 2N, so one conditional subtract each.
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] x_op, y_op, p_next;
    logic [WIDTH+1:0] n_ext, dbl, red, sum;
    logic             y_bit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        x_op = acc;
        y_op = acc;
        if (state == MUL) begin
            x_op = mode_r ? m_reg : acc;
            y_op = mode_r ? e_reg : m_reg;
        end
        y_bit  = y_op[cnt];
        n_ext  = {2'b00, n_reg};
        dbl    = {1'b0, p, 1'b0};
        red    = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum    = red + (y_bit ? {2'b00, x_op} : '0);
        p_next = (sum >= n_ext) ? WIDTH'(sum - n_ext) : WIDTH'(sum);
    end

    always_comb begin
        rd_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (32'(addr) == k) rd_byte = result[8*k +: 8];
        end
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_go) state_next = INIT;
            INIT: begin
                if (operands_bad) state_next = FIN;
                else              state_next = mode_r ? MUL : SQR;
            end
            SQR: begin
                if (cnt_last) begin
                    if (e_reg[bit_idx])        state_next = MUL;
                    else if (bit_idx == '0)    state_next = FIN;
                    else                       state_next = SQR;
                end
            end
            MUL: begin
                if (cnt_last) begin
                    if (mode_r || bit_idx == '0) state_next = FIN;
                    else                         state_next = SQR;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Operand registers, datapath and read port
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: operand and result registers are cleared explicitly; an
            // aborted run must not leave stale data readable on the bus.
            m_reg       <= '0;
            e_reg       <= '0;
            n_reg       <= '0;
            result      <= '0;
            acc         <= '0;
            p           <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            mode_r      <= 1'b0;
            err_r       <= 1'b0;
            bus.data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.we && addr_ok) begin
                        for (int k = 0; k < NB; k++) begin
                            if (32'(addr) == k) begin
                                case (bus.reg_sel)
                                    2'b01:   m_reg[8*k +: 8] <= bus.data_i;
                                    2'b10:   e_reg[8*k +: 8] <= bus.data_i;
                                    2'b11:   n_reg[8*k +: 8] <= bus.data_i;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    if (start_go) begin
                        mode_r <= bus.mode;
                        err_r  <= 1'b0;
                    end
                end
                INIT: begin
                    if (operands_bad) begin
                        err_r  <= 1'b1;
                        result <= '0;
                    end else begin
                        acc <= mode_r ? m_reg : WIDTH'(1);
                    end
                    p       <= '0;
                    cnt     <= IW'(WIDTH - 1);
                    bit_idx <= IW'(WIDTH - 1);
                end
                SQR, MUL: begin
                    if (cnt_last) begin
                        acc <= p_next;
                        p   <= '0;
                        cnt <= IW'(WIDTH - 1);
                        if (state_next == FIN) result <= p_next;
                        // Moving on to the next exponent bit
                        if (state_next == SQR) bit_idx <= bit_idx - 1'b1;
                    end else begin
                        p   <= p_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase

            if (bus.oe && bus.ready && bus.reg_sel == 2'b00 && addr_ok)
                bus.data_o <= rd_byte;
            else
                bus.data_o <= '0;
        end
    end
endmodule

// File: tb/tb_rsa_modexp_param.sv
// Scoreboard bench for rsa_modexp_param at WIDTH=16: expected result, error
// flag and latency are queued at start and compared when done pulses.
module tb_rsa_modexp_param;
    localparam int WIDTH  = 16;
    localparam int AW     = 1;
    localparam int NB     = WIDTH / 8;
    localparam int BUDGET = 4000;

    typedef struct {
        int unsigned res;
        logic        err;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rsa_modexp_param_if #(.AW(AW)) bus ();

    rsa_modexp_param #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned mod_exp(input int unsigned m, input int unsigned e,
                                            input int unsigned n);
        longint r = 1 % n;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * m) % n;
        end
        return int'(r);
    endfunction

    task automatic write_reg(input logic [1:0] sel, input int unsigned v);
        for (int k = 0; k < NB; k++) begin
            bus.we      = 1'b1;
            bus.reg_sel = sel;
            bus.addr    = AW'(k);
            bus.data_i  = 8'(v >> (8 * k));
            step();
        end
        bus.we = 1'b0;
    endtask

    task automatic read_result(output int unsigned v);
        v = 0;
        for (int k = 0; k < NB; k++) begin
            bus.oe      = 1'b1;
            bus.reg_sel = 2'b00;
            bus.addr    = AW'(k);
            step();
            v = v | (int'(bus.data_o) << (8 * k));
        end
        bus.oe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Loads operands (optionally), starts, waits for done and scores the run.
    // With inject set, a write and a read are attempted mid-run; both must be ignored.
    task automatic run_op(input logic md, input int unsigned m, input int unsigned e,
                          input int unsigned n, input bit do_load, input bit inject);
        exp_t        x;
        exp_t        got;
        int          cycles;
        int unsigned r;
        if (n == 0 || m >= n) begin
            x.res = 0; x.err = 1'b1; x.lat = 1;
        end else if (md) begin
            x.res = int'((longint'(m) * longint'(e)) % n);
            x.err = 1'b0; x.lat = 1 + WIDTH;
        end else begin
            x.res = mod_exp(m, e, n);
            x.err = 1'b0; x.lat = 1 + (WIDTH + $countones(e)) * WIDTH;
        end
        if (do_load) begin
            write_reg(2'b01, m);
            write_reg(2'b10, e);
            write_reg(2'b11, n);
        end
        sb.push_back(x);
        bus.mode  = md;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cycles = 0;
        while (!bus.done && cycles < BUDGET) begin
            if (inject && cycles == 3) begin
                bus.we = 1'b1; bus.reg_sel = 2'b01; bus.addr = '0; bus.data_i = 8'hFF;
                bus.oe = 1'b1;
            end else begin
                bus.we = 1'b0; bus.oe = 1'b0; bus.reg_sel = 2'b00;
            end
            step();
            cycles++;
            if (cycles == 2 && !bus.done) check("busy_ready", bus.ready, 0);
            if (inject && cycles == 4) check("busy_read", bus.data_o, 0);
        end
        bus.we = 1'b0;
        bus.oe = 1'b0;
        got = sb.pop_front();
        check("done_seen", bus.done, 1);
        if (bus.done) begin
            check("latency", cycles, got.lat);
            check("err", bus.err, got.err);
            step();
            check("done_pulse", bus.done, 0);
            check("ready_after", bus.ready, 1);
            read_result(r);
            check("result", r, got.res);
            check("err_held", bus.err, got.err);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        int          seen;
        int unsigned n, m, e;
        bus.we = 1'b0; bus.oe = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
        bus.reg_sel = 2'b00; bus.addr = '0; bus.data_i = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_data_o", bus.data_o, 0);
        read_result(r);
        check("rst_result", r, 0);

        // Reference exponentiation, multiply and operand error
        run_op(1'b0, 4, 13, 497, 1'b1, 1'b0);
        check("ref_445", 445, mod_exp(4, 13, 497));

        // Read from a non-result register and a write to the result register
        bus.oe = 1'b1; bus.reg_sel = 2'b01; bus.addr = '0;
        step();
        bus.oe = 1'b0;
        check("read_sel01", bus.data_o, 0);
        step();
        check("read_no_oe", bus.data_o, 0);
        write_reg(2'b00, 16'h1234);
        read_result(r);
        check("result_ro", r, 445);

        run_op(1'b1, 300, 400, 497, 1'b1, 1'b0);
        run_op(1'b0, 500, 13, 497, 1'b1, 1'b0);
        run_op(1'b0, 0, 0, 1, 1'b1, 1'b0);
        run_op(1'b0, 5, 0, 497, 1'b1, 1'b0);
        run_op(1'b1, 100, 60000, 497, 1'b1, 1'b0);
        run_op(1'b0, 7, 16'hFFFF, 65521, 1'b1, 1'b1);

        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(2, 65535);
            m = $urandom_range(0, n - 1);
            e = $urandom_range(0, 65535);
            run_op(1'(t), m, e, n, 1'b1, t == 2);
        end

        // Write together with start: write lands, no operation starts
        run_op(1'b1, 7, 5, 497, 1'b1, 1'b0);
        bus.we = 1'b1; bus.start = 1'b1; bus.mode = 1'b1;
        bus.reg_sel = 2'b01; bus.addr = '0; bus.data_i = 8'd9;
        step();
        bus.we = 1'b0; bus.start = 1'b0;
        check("we_start_ready", bus.ready, 1);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.done || !bus.ready) seen++;
        end
        check("we_start_idle", seen, 0);
        run_op(1'b1, 9, 5, 497, 1'b0, 1'b0);

        // Reset partway through an exponentiation
        write_reg(2'b01, 4);
        write_reg(2'b10, 13);
        write_reg(2'b11, 497);
        bus.mode = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.done) seen++;
        end
        do_reset();
        check("abort_ready", bus.ready, 1);
        check("abort_err", bus.err, 0);
        check("abort_data_o", bus.data_o, 0);
        for (int c = 0; c < 400; c++) begin
            step();
            if (bus.done) seen++;
        end
        check("abort_no_done", seen, 0);
        read_result(r);
        check("abort_result", r, 0);
        // N was cleared by reset, so a start without reloading must flag an error
        run_op(1'b1, 0, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
